// File: rtl/ecc_correct_pipe.sv
// SEC/DED correction back end: flips the bit named by the syndrome, strips parity
// and returns the data word through a two-stage valid/ready pipeline with error counters.
module ecc_correct_pipe #(
  parameter int DATA_S = 8,
  parameter int SYN_S  = 4,
  parameter int DATA_M = 16,
  parameter int SYN_M  = 5,
  parameter int DATA_L = 32,
  parameter int SYN_L  = 6,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_L+SYN_L:0]   in_cw,
  input  logic [SYN_L-1:0]        in_syn,
  input  logic [1:0]              in_nof,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_L-1:0]       out_data,
  output logic                    out_corr,
  output logic                    out_uncorr,
  output logic [5:0]              out_pos,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        cnt_corr,
  output logic [CNT_W-1:0]        cnt_uncorr
);

  localparam int CW_S = DATA_S + SYN_S + 1;
  localparam int CW_M = DATA_M + SYN_M + 1;
  localparam int CW_L = DATA_L + SYN_L + 1;

  logic [7:0]       par_w, cw_w, lg, syn_m, pos_c;
  logic [SYN_L-1:0] syn_v;
  logic             is_pow, pos_ok, cls_corr, cls_uncorr;
  logic [CW_L-1:0]  mask_c, fixed_c;
  logic [DATA_L-1:0] data_c;
  logic             s1_adv, s2_adv, fire;

  logic              s1_valid_q, s1_valid_d;
  logic [CW_L-1:0]   s1_cw_q, s1_cw_d;
  logic [CW_L-1:0]   s1_mask_q, s1_mask_d;
  logic              s1_corr_q, s1_corr_d;
  logic              s1_uncorr_q, s1_uncorr_d;
  logic [1:0]        s1_mode_q, s1_mode_d;
  logic [5:0]        s1_pos_q, s1_pos_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_L-1:0] out_data_q, out_data_d;
  logic              out_corr_q, out_corr_d;
  logic              out_uncorr_q, out_uncorr_d;
  logic [5:0]        out_pos_q, out_pos_d;
  logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

  // Syndrome to codeword position: zero names the overall parity bit, powers of two
  // name Hamming parity bits, everything else ranks into the data field.
  always_comb begin
    par_w = 8'(SYN_L);
    cw_w  = 8'(CW_L);
    case (in_mode)
      2'd0: begin par_w = 8'(SYN_S); cw_w = 8'(CW_S); end
      2'd1: begin par_w = 8'(SYN_M); cw_w = 8'(CW_M); end
      default: ;
    endcase
    syn_v = '0;
    for (int i = 0; i < SYN_L; i++) syn_v[i] = in_syn[i] & (8'(i) < par_w);
    syn_m = 8'(syn_v);
    lg = '0;
    for (int i = 0; i < SYN_L; i++) if (syn_v[i]) lg = 8'(i);
    is_pow = (syn_v != '0) && ((syn_v & (syn_v - SYN_L'(1))) == '0);
    if (syn_v == '0)  pos_c = par_w;
    else if (is_pow)  pos_c = lg;
    else              pos_c = syn_m - lg - 8'd2 + par_w + 8'd1;
    pos_ok     = pos_c < cw_w;
    cls_corr   = 1'b0;
    cls_uncorr = 1'b0;
    if (in_mode == 2'd3 || in_nof[1]) cls_uncorr = 1'b1;
    else if (in_nof == 2'd1) begin
      if (pos_ok) cls_corr   = 1'b1;
      else        cls_uncorr = 1'b1;
    end
    mask_c = cls_corr ? (CW_L'(1) << pos_c) : '0;
  end

  always_comb begin
    fixed_c = s1_cw_q ^ s1_mask_q;
    case (s1_mode_q)
      2'd0:    data_c = DATA_L'(fixed_c[CW_S-1:SYN_S+1]);
      2'd1:    data_c = DATA_L'(fixed_c[CW_M-1:SYN_M+1]);
      2'd2:    data_c = fixed_c[CW_L-1:SYN_L+1];
      default: data_c = '0;
    endcase
  end

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign fire     = out_valid_q && out_ready;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_cw_d      = s1_cw_q;
    s1_mask_d    = s1_mask_q;
    s1_corr_d    = s1_corr_q;
    s1_uncorr_d  = s1_uncorr_q;
    s1_mode_d    = s1_mode_q;
    s1_pos_d     = s1_pos_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    out_pos_d    = out_pos_q;
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_cw_d     = in_cw;
        s1_mask_d   = mask_c;
        s1_corr_d   = cls_corr;
        s1_uncorr_d = cls_uncorr;
        s1_mode_d   = in_mode;
        s1_pos_d    = cls_corr ? pos_c[5:0] : 6'd0;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = data_c;
        out_corr_d   = s1_corr_q;
        out_uncorr_d = s1_uncorr_q;
        out_pos_d    = s1_pos_q;
      end
    end

    // Clear wins over an increment landing in the same cycle.
    if (clr_cnt) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (fire) begin
      if (out_corr_q && cnt_corr_q != '1)     cnt_corr_d   = cnt_corr_q + CNT_W'(1);
      if (out_uncorr_q && cnt_uncorr_q != '1) cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_cw_q      <= '0;
      s1_mask_q    <= '0;
      s1_corr_q    <= 1'b0;
      s1_uncorr_q  <= 1'b0;
      s1_mode_q    <= 2'd0;
      s1_pos_q     <= 6'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
      out_pos_q    <= 6'd0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_cw_q      <= s1_cw_d;
      s1_mask_q    <= s1_mask_d;
      s1_corr_q    <= s1_corr_d;
      s1_uncorr_q  <= s1_uncorr_d;
      s1_mode_q    <= s1_mode_d;
      s1_pos_q     <= s1_pos_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
      out_pos_q    <= out_pos_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_corr   = out_corr_q;
  assign out_uncorr = out_uncorr_q;
  assign out_pos    = out_pos_q;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_ecc_correct_pipe.sv
// Scoreboard bench for ecc_correct_pipe: directed vectors push expected results,
// a negedge monitor pops and compares each delivered transaction.
module tb_ecc_correct_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [38:0] in_cw;
  logic [5:0]  in_syn;
  logic [1:0]  in_nof;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_corr;
  logic        out_uncorr;
  logic [5:0]  out_pos;
  logic        clr_cnt;
  logic [15:0] cnt_corr;
  logic [15:0] cnt_uncorr;

  typedef struct packed {
    logic [31:0] data;
    logic        corr;
    logic        uncorr;
    logic [5:0]  pos;
  } exp_t;

  exp_t sb[$];
  int   assertions_cnt = 0;
  int   failures = 0;
  logic [31:0] held_data;

  ecc_correct_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cw(in_cw), .in_syn(in_syn), .in_nof(in_nof), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_corr(out_corr), .out_uncorr(out_uncorr), .out_pos(out_pos),
    .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions_cnt++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportError(input string name);
    assertions_cnt++;
    failures++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic applyStimulus(input logic [38:0] cw, input logic [5:0] syn,
                               input logic [1:0] nof, input logic [1:0] mode,
                               input logic [31:0] d, input logic c, input logic u,
                               input logic [5:0] p);
    bit   acc;
    int   guard;
    exp_t e;
    in_valid = 1'b1;
    in_cw    = cw;
    in_syn   = syn;
    in_nof   = nof;
    in_mode  = mode;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (acc) begin
      e.data   = d;
      e.corr   = c;
      e.uncorr = u;
      e.pos    = p;
      sb.push_back(e);
    end else reportError("accept_timeout");
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 500) begin
      @(posedge clk);
      #2;
      g++;
    end
    if (g >= 500) reportError("drain_timeout");
  endtask

  // Every delivered transaction must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) reportError("unexpected_output");
      else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_data",   64'(out_data),   64'(e.data));
        checkOutput("out_corr",   64'(out_corr),   64'(e.corr));
        checkOutput("out_uncorr", 64'(out_uncorr), 64'(e.uncorr));
        checkOutput("out_pos",    64'(out_pos),    64'(e.pos));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_cw = '0; in_syn = '0; in_nof = '0; in_mode = '0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid",  64'(out_valid),  64'd0);
    checkOutput("rst_out_data",   64'(out_data),   64'd0);
    checkOutput("rst_out_pos",    64'(out_pos),    64'd0);
    checkOutput("rst_cnt_corr",   64'(cnt_corr),   64'd0);
    checkOutput("rst_cnt_uncorr", 64'(cnt_uncorr), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Small mode, syndrome 3 names bit 5; latency is two edges.
    applyStimulus(39'h1480, 6'd3, 2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd5);
    idle();
    @(negedge clk);
    checkOutput("latency_s1", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("latency_s2", 64'(out_valid), 64'd1);
    waitDrain();
    checkOutput("cnt_corr_t1",   64'(cnt_corr),   64'd1);
    checkOutput("cnt_uncorr_t1", 64'(cnt_uncorr), 64'd0);

    applyStimulus(39'h3FFFC0, 6'd0, 2'd2, 2'd1, 32'hFFFF, 1'b0, 1'b1, 6'd0);
    idle();
    waitDrain();
    checkOutput("cnt_uncorr_t3", 64'(cnt_uncorr), 64'd1);
    checkOutput("cnt_corr_t3",   64'(cnt_corr),   64'd1);

    // Back-to-back directed vectors across all modes and position boundaries.
    applyStimulus(39'h14B0, 6'd0,  2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd4);
    applyStimulus(39'h14A4, 6'd4,  2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd2);
    applyStimulus(39'h7FFFFFF4A7, 6'd5, 2'd0, 2'd0, 32'hA5, 1'b0, 1'b0, 6'd0);
    applyStimulus(39'h1480, 6'h33, 2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd5);
    applyStimulus(39'h04A0, 6'd12, 2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd12);
    applyStimulus(39'h14A0, 6'd13, 2'd1, 2'd0, 32'hA5, 1'b0, 1'b1, 6'd0);
    applyStimulus(39'h14A0, 6'h0E, 2'd1, 2'd0, 32'hA5, 1'b0, 1'b1, 6'd0);
    applyStimulus((39'h12345678 << 7) ^ (39'd1 << 11), 6'd9, 2'd1, 2'd2, 32'h12345678, 1'b1, 1'b0, 6'd11);
    applyStimulus((39'h0DEADBEE << 7) ^ 39'd1, 6'd1, 2'd1, 2'd2, 32'h0DEADBEE, 1'b1, 1'b0, 6'd0);
    applyStimulus(39'h12345678 << 7, 6'd63, 2'd1, 2'd2, 32'h12345678, 1'b0, 1'b1, 6'd0);
    applyStimulus((39'h12345678 << 7) ^ (39'd1 << 38), 6'd38, 2'd1, 2'd2, 32'h12345678, 1'b1, 1'b0, 6'd38);
    applyStimulus(39'h2FB9C0, 6'd7, 2'd1, 2'd1, 32'hBEEF, 1'b1, 1'b0, 6'd9);
    applyStimulus(39'h2FBBC0, 6'd0, 2'd3, 2'd1, 32'hBEEF, 1'b0, 1'b1, 6'd0);
    applyStimulus(39'h3FFFC0, 6'd0, 2'd2, 2'd3, 32'h0, 1'b0, 1'b1, 6'd0);
    applyStimulus(39'h7FFFFFFFFF, 6'd0, 2'd0, 2'd3, 32'h0, 1'b0, 1'b1, 6'd0);
    idle();
    waitDrain();

    // Backpressure: two accepted, then in_ready drops and outputs hold.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(39'h11 << 5, 6'd0, 2'd0, 2'd0, 32'h11, 1'b0, 1'b0, 6'd0);
        applyStimulus(39'h22 << 5, 6'd0, 2'd0, 2'd0, 32'h22, 1'b0, 1'b0, 6'd0);
        applyStimulus(39'h33 << 5, 6'd0, 2'd0, 2'd0, 32'h33, 1'b0, 1'b0, 6'd0);
        applyStimulus(39'h44 << 5, 6'd0, 2'd0, 2'd0, 32'h44, 1'b0, 1'b0, 6'd0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        checkOutput("bp_in_ready",  64'(in_ready),  64'd0);
        checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_out_data",  64'(out_data),  64'h11);
        held_data = out_data;
        @(negedge clk);
        checkOutput("bp_hold_data",  64'(out_data), 64'(held_data));
        checkOutput("bp_hold_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();

    // Saturation of the corrected counter.
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    checkOutput("clr_cnt_corr",   64'(cnt_corr),   64'd0);
    checkOutput("clr_cnt_uncorr", 64'(cnt_uncorr), 64'd0);
    for (int i = 0; i < 65535; i++)
      applyStimulus(39'h14B0, 6'd0, 2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd4);
    idle();
    waitDrain();
    checkOutput("cnt_full", 64'(cnt_corr), 64'hFFFF);
    applyStimulus(39'h14B0, 6'd0, 2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd4);
    idle();
    waitDrain();
    checkOutput("cnt_saturate", 64'(cnt_corr), 64'hFFFF);

    // Clear against a same-cycle increment.
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    applyStimulus(39'h14B0, 6'd0, 2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd4);
    idle();
    waitDrain();
    checkOutput("cnt_one", 64'(cnt_corr), 64'd1);
    out_ready = 1'b0;
    applyStimulus(39'h14B0, 6'd0, 2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd4);
    idle();
    begin
      int g;
      g = 0;
      while (!out_valid && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (!out_valid) reportError("stall_wait");
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    checkOutput("clr_priority", 64'(cnt_corr), 64'd0);
    waitDrain();

    // Asynchronous reset with two transactions in flight.
    applyStimulus(39'h1480, 6'd3, 2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd5);
    applyStimulus(39'h14A4, 6'd4, 2'd1, 2'd0, 32'hA5, 1'b1, 1'b0, 6'd2);
    idle();
    rst = 1'b0;
    #1;
    sb.delete();
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_data",  64'(out_data),  64'd0);
    checkOutput("midrst_out_corr",  64'(out_corr),  64'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_next_edge", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready",  64'(in_ready),  64'd1);
    checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(39'h2FB9C0, 6'd7, 2'd1, 2'd1, 32'hBEEF, 1'b1, 1'b0, 6'd9);
    idle();
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions_cnt, failures);
    $finish;
  end

endmodule
